vga_frame_sched: RTL and testbench
==================================

// Module: vga_frame_sched
// PURPOSE
//  Frame-synchronous configuration scheduler for the VGA pixel datapath. A host
//  writes colour and pattern settings at any time; writes land in shadow registers.
//  The block commits them to the live outputs only at the start of vertical blanking,
//  so a frame never tears. In auto mode it also steps the pattern select every N frames.
// PARAMETERS
//  COUNT_W   10   width of count_h / count_v
//  V_ACTIVE  480  first blanking line; commit line
//  DEF_FG    12'hFFF  reset value of foreground colour {r,g,b}
//  DEF_BG    12'h000  reset value of background colour {r,g,b}
//  DEF_PER   8'd60    reset value of auto-step period, in frames
// PORTS
//  clk          in   1        pixel clock
//  rst          in   1        synchronous reset, active-high
//  count_h      in   COUNT_W  horizontal counter from timing generator
//  count_v      in   COUNT_W  vertical counter from timing generator
//  cfg_valid    in   1        host write request
//  cfg_ready    out  1        write accepted this cycle when valid&ready
//  cfg_addr     in   2        0=bg 1=fg 2=mode 3=period
//  cfg_data     in   12       write data; mode uses [2:0], period uses [7:0]
//  bg_colour    out  12       live background colour
//  fg_colour    out  12       live foreground colour
//  pattern_sel  out  2        live pattern select
//  frame_cnt    out  8        frames since reset, wraps 255->0
//  commit       out  1        1-cycle pulse when shadows are copied to live
// BEHAVIOUR
//  Clock domain: everything is on clk. Reset is synchronous and active-high.
//  Reset: bg_colour=DEF_BG, fg_colour=DEF_FG, pattern_sel=0, auto=0, period=DEF_PER.
//   The shadow registers take the same values. frame_cnt=0, commit=0, cfg_ready=1.
//   State resets to CLEAN.
//  frame_tick (comb) = (count_v==V_ACTIVE) && (count_h==0). It is true one cycle per frame.
//  Shadow write: when cfg_valid && cfg_ready, store cfg_data to shadow[cfg_addr] next edge.
//   mode: [1:0] = pattern, [2] = auto enable. period: 0 is treated as 1.
//  FSM states: CLEAN, DIRTY, COMMIT.
//   CLEAN  -> DIRTY  on an accepted write.
//   DIRTY  -> COMMIT on frame_tick; stays DIRTY on further writes.
//   COMMIT -> CLEAN after 1 cycle; -> DIRTY if a write is accepted in that cycle.
//  cfg_ready is 0 only when frame_tick && state==DIRTY. Writes held on that cycle
//   stall and are accepted next cycle.
//  Entering COMMIT copies all shadows to live at the same edge. commit=1 for exactly
//   the COMMIT cycle. Latency from accepted write to live output: until next frame_tick +1.
//  frame_cnt increments at every frame_tick edge, independent of FSM state.
//  Auto step: an internal 8-bit age counter increments on frame_tick while live auto=1.
//   When age reaches period-1 on a frame_tick, pattern_sel<=pattern_sel+1 (wraps 3->0)
//   and age<=0.
//   The shadow pattern is also updated to this value, so that a later commit of other
//   fields does not revert it.
//   If a commit and an auto step fall on the same frame_tick, the commit wins: the live
//   pattern takes the shadow value and age<=0.
//   age clears whenever auto is 0.
//  Writes of the same value still mark DIRTY and produce a commit pulse.
//  A reset mid-frame or mid-commit discards all pending shadows; no commit pulse follows.
//  count_h/count_v are sampled only by comparison. Out-of-range counts never commit.
// TESTING
//  1) Reset, then idle 2 frames -> bg=000 fg=FFF pattern=0; commit never pulses;
//     frame_cnt=2.
//  2) Write bg=0F0 at v=100 -> bg stays 000 until the v=480,h=0 edge, then 0F0 with a
//     1-cycle commit pulse.
//  3) Hold cfg_valid on the frame_tick cycle while DIRTY -> cfg_ready=0 that cycle,
//     write accepted next cycle, a second commit occurs next frame.
//  4) mode=3'b100, period=2 -> pattern_sel 0,1,2,3,0 at every 2nd frame_tick.
//  5) Auto running; write fg=F00 so its commit coincides with an auto step -> pattern
//     holds its shadow value, age restarts, fg=F00.
//  6) Assert rst for 1 cycle while DIRTY -> next frame_tick has no commit; outputs
//     at reset values.

Source files
------------

// File: rtl/vga_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : vga_frame_sched
//  Purpose  : Shadows host colour/pattern writes and commits them to the live
//             outputs at the start of vertical blanking; optional auto-step of
//             the pattern select every N frames.
//  Revision : 1.0  initial release
// ============================================================================
module vga_frame_sched #(
    parameter int          COUNT_W  = 10,
    parameter int          V_ACTIVE = 480,
    parameter logic [11:0] DEF_FG   = 12'hFFF,
    parameter logic [11:0] DEF_BG   = 12'h000,
    parameter logic [7:0]  DEF_PER  = 8'd60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] count_h_i,
    input  logic [COUNT_W-1:0] count_v_i,
    input  logic               cfg_valid_i,
    output logic               cfg_ready_o,
    input  logic [1:0]         cfg_addr_i,
    input  logic [11:0]        cfg_data_i,
    output logic [11:0]        bg_colour_o,
    output logic [11:0]        fg_colour_o,
    output logic [1:0]         pattern_sel_o,
    output logic [7:0]         frame_cnt_o,
    output logic               commit_o
);

    localparam logic [COUNT_W-1:0] C_V_ACTIVE = COUNT_W'(V_ACTIVE);
    localparam logic [7:0]         C_DEF_PER  = (DEF_PER == 8'd0) ? 8'd1 : DEF_PER;

    typedef enum logic [1:0] {
        ST_CLEAN  = 2'd0,
        ST_DIRTY  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t      state_q;

    logic [11:0] sh_bg_q,  bg_q;
    logic [11:0] sh_fg_q,  fg_q;
    logic [1:0]  sh_pat_q, pat_q;
    logic        sh_auto_q, auto_q;
    logic [7:0]  sh_per_q, per_q;
    logic [7:0]  age_q;
    logic [7:0]  frame_cnt_q;
    logic        commit_q;

    logic        w_frame_tick;
    logic        w_do_commit;
    logic        w_accept;
    logic [1:0]  pat_d;
    logic [7:0]  per_d;

    assign w_frame_tick = (count_v_i == C_V_ACTIVE) && (count_h_i == '0);
    assign w_do_commit  = w_frame_tick && (state_q == ST_DIRTY);
    assign cfg_ready_o  = !w_do_commit;
    assign w_accept     = cfg_valid_i && cfg_ready_o;
    assign pat_d        = pat_q + 2'd1;
    // Period 0 is stored as 1 so the age compare below never underflows.
    assign per_d        = (cfg_data_i[7:0] == 8'd0) ? 8'd1 : cfg_data_i[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAN;
            sh_bg_q     <= DEF_BG;
            sh_fg_q     <= DEF_FG;
            sh_pat_q    <= 2'd0;
            sh_auto_q   <= 1'b0;
            sh_per_q    <= C_DEF_PER;
            bg_q        <= DEF_BG;
            fg_q        <= DEF_FG;
            pat_q       <= 2'd0;
            auto_q      <= 1'b0;
            per_q       <= C_DEF_PER;
            age_q       <= 8'd0;
            frame_cnt_q <= 8'd0;
            commit_q    <= 1'b0;
        end else begin
            if (w_frame_tick) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
            commit_q <= w_do_commit;

            case (state_q)
                ST_CLEAN:  if (w_accept) state_q <= ST_DIRTY;
                ST_DIRTY:  if (w_frame_tick) state_q <= ST_COMMIT;
                ST_COMMIT: state_q <= w_accept ? ST_DIRTY : ST_CLEAN;
                default:   state_q <= ST_CLEAN;
            endcase

            // A commit takes priority over an auto step on the same tick.
            if (w_do_commit) begin
                bg_q   <= sh_bg_q;
                fg_q   <= sh_fg_q;
                pat_q  <= sh_pat_q;
                auto_q <= sh_auto_q;
                per_q  <= sh_per_q;
                age_q  <= 8'd0;
            end else if (!auto_q) begin
                age_q <= 8'd0;
            end else if (w_frame_tick) begin
                if (age_q == per_q - 8'd1) begin
                    pat_q    <= pat_d;
                    sh_pat_q <= pat_d;
                    age_q    <= 8'd0;
                end else begin
                    age_q <= age_q + 8'd1;
                end
            end

            // Host writes land after the auto-step shadow update so they win.
            if (w_accept) begin
                case (cfg_addr_i)
                    2'd0: sh_bg_q <= cfg_data_i;
                    2'd1: sh_fg_q <= cfg_data_i;
                    2'd2: begin
                        sh_pat_q  <= cfg_data_i[1:0];
                        sh_auto_q <= cfg_data_i[2];
                    end
                    default: sh_per_q <= per_d;
                endcase
            end
        end
    end

    assign bg_colour_o   = bg_q;
    assign fg_colour_o   = fg_q;
    assign pattern_sel_o = pat_q;
    assign frame_cnt_o   = frame_cnt_q;
    assign commit_o      = commit_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_frame_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_frame_sched
//  Purpose  : Directed self-checking bench for vga_frame_sched; the counters
//             are driven directly so frame ticks can be placed at will.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_frame_sched;

    logic        clk;
    logic        rst;
    logic [9:0]  count_h;
    logic [9:0]  count_v;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_addr;
    logic [11:0] cfg_data;
    logic [11:0] bg_colour;
    logic [11:0] fg_colour;
    logic [1:0]  pattern_sel;
    logic [7:0]  frame_cnt;
    logic        commit;

    int          n_vec;
    int          n_err;
    int          fc;

    vga_frame_sched u_dut (
        .clk           (clk),
        .rst           (rst),
        .count_h_i     (count_h),
        .count_v_i     (count_v),
        .cfg_valid_i   (cfg_valid),
        .cfg_ready_o   (cfg_ready),
        .cfg_addr_i    (cfg_addr),
        .cfg_data_i    (cfg_data),
        .bg_colour_o   (bg_colour),
        .fg_colour_o   (fg_colour),
        .pattern_sel_o (pattern_sel),
        .frame_cnt_o   (frame_cnt),
        .commit_o      (commit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_counts();
        count_v = 10'd100;
        count_h = 10'd3;
    endtask

    task automatic write(input logic [1:0] addr, input logic [11:0] data);
        cfg_valid = 1'b1;
        cfg_addr  = addr;
        cfg_data  = data;
        #1;
        chk("wr_ready", cfg_ready, 1'b1);
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_tick(input logic exp_commit);
        count_v = 10'd480;
        count_h = 10'd0;
        step();
        idle_counts();
        fc++;
        chk("tick_commit", commit, exp_commit);
        chk("frame_cnt", frame_cnt, fc[7:0]);
        step();
        chk("commit_drop", commit, 1'b0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        fc        = 0;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_addr  = 2'd0;
        cfg_data  = 12'h000;
        idle_counts();
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_bg", bg_colour, 12'h000);
        chk("rst_fg", fg_colour, 12'hFFF);
        chk("rst_pat", pattern_sel, 2'd0);
        chk("rst_fcnt", frame_cnt, 8'd0);
        chk("rst_commit", commit, 1'b0);
        chk("rst_ready", cfg_ready, 1'b1);

        // Idle two frames: no commits
        do_tick(1'b0);
        do_tick(1'b0);
        chk("idle_bg", bg_colour, 12'h000);
        chk("idle_fg", fg_colour, 12'hFFF);
        chk("idle_fcnt", frame_cnt, 8'd2);

        // bg write held in shadow until the blanking tick
        write(2'd0, 12'h0F0);
        step();
        step();
        chk("bg_shadow", bg_colour, 12'h000);
        do_tick(1'b1);
        chk("bg_live", bg_colour, 12'h0F0);

        // Out-of-range or off-column counts never commit
        write(2'd1, 12'h0AA);
        count_v = 10'd600;
        count_h = 10'd0;
        step();
        chk("oor_commit", commit, 1'b0);
        count_v = 10'd480;
        count_h = 10'd1;
        step();
        chk("h1_commit", commit, 1'b0);
        chk("h1_fcnt", frame_cnt, fc[7:0]);
        idle_counts();
        chk("oor_fg", fg_colour, 12'hFFF);
        do_tick(1'b1);
        chk("fg_live", fg_colour, 12'h0AA);

        // Write held across the commit tick stalls one cycle
        write(2'd1, 12'h123);
        count_v   = 10'd480;
        count_h   = 10'd0;
        cfg_valid = 1'b1;
        cfg_addr  = 2'd0;
        cfg_data  = 12'h00F;
        #1;
        chk("stall_ready", cfg_ready, 1'b0);
        step();
        fc++;
        count_h = 10'd1;
        #1;
        chk("stall_ready_next", cfg_ready, 1'b1);
        chk("stall_commit", commit, 1'b1);
        chk("stall_fg", fg_colour, 12'h123);
        chk("stall_bg", bg_colour, 12'h0F0);
        step();
        cfg_valid = 1'b0;
        idle_counts();
        chk("stall_commit_drop", commit, 1'b0);
        do_tick(1'b1);
        chk("stall_bg_live", bg_colour, 12'h00F);

        // Auto step: period 2, pattern advances every second tick
        write(2'd2, 12'h004);
        write(2'd3, 12'h002);
        do_tick(1'b1);
        chk("auto_start", pattern_sel, 2'd0);
        for (int i = 1; i <= 8; i++) begin
            logic [31:0] q;
            do_tick(1'b0);
            q = (i / 2) % 4;
            chk("auto_pat", pattern_sel, q);
        end

        // Commit on an auto-step tick keeps the shadow pattern
        do_tick(1'b0);
        do_tick(1'b0);
        chk("pre_pat", pattern_sel, 2'd1);
        do_tick(1'b0);
        write(2'd1, 12'hF00);
        do_tick(1'b1);
        chk("coll_pat", pattern_sel, 2'd1);
        chk("coll_fg", fg_colour, 12'hF00);
        do_tick(1'b0);
        chk("coll_age1", pattern_sel, 2'd1);
        do_tick(1'b0);
        chk("coll_age2", pattern_sel, 2'd2);

        // Reset while dirty discards pending shadows
        write(2'd0, 12'h777);
        rst = 1'b1;
        step();
        rst = 1'b0;
        fc  = 0;
        chk("mid_rst_fcnt", frame_cnt, 8'd0);
        chk("mid_rst_pat", pattern_sel, 2'd0);
        do_tick(1'b0);
        chk("mid_rst_bg", bg_colour, 12'h000);
        chk("mid_rst_fg", fg_colour, 12'hFFF);
        do_tick(1'b0);
        chk("mid_rst_auto", pattern_sel, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
